// File: rtl/vga_timing_gen.sv
// Raster timing generator: sync, blank, coordinates and line/frame strobes with a PIX_DIV pixel divider.
// Outputs registered with zero lag to the counters; Enable low freezes everything. Option: VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int H_DISPLAY     = 800,
  parameter int H_FRONT_PORCH = 56,
  parameter int H_SYNC_PULSE  = 120,
  parameter int H_BACK_PORCH  = 64,
  parameter int V_DISPLAY     = 600,
  parameter int V_FRONT_PORCH = 37,
  parameter int V_SYNC_PULSE  = 6,
  parameter int V_BACK_PORCH  = 23,
  parameter bit H_SYNC_POL    = 1'b1,
  parameter bit V_SYNC_POL    = 1'b1,
  parameter int PIX_DIV       = 1,
  parameter int X_WIDTH       = 11,
  parameter int Y_WIDTH       = 10
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Enable,
  output logic               hSync,
  output logic               vSync,
  output logic               sync_n,
  output logic               blank_n,
  output logic [X_WIDTH-1:0] nextX,
  output logic [Y_WIDTH-1:0] nextY,
  output logic               pixelTick,
  output logic               lineStart,
  output logic               frameStart
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0]        frameCount
`endif
);

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT_PORCH;
  localparam int H_BACK_START = H_SYNC_START + H_SYNC_PULSE;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT_PORCH;
  localparam int V_BACK_START = V_SYNC_START + V_SYNC_PULSE;
  localparam int DIV_W        = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} v_state_t;

  logic [DIV_W-1:0]   div_cnt;
  logic [X_WIDTH-1:0] h_cnt, h_cnt_nxt;
  logic [Y_WIDTH-1:0] v_cnt, v_cnt_nxt;
  h_state_t           h_state, h_state_nxt;
  v_state_t           v_state, v_state_nxt;
  logic               tick, h_wrap, v_wrap;
  logic               act_nxt, hs_act_nxt, vs_act_nxt;

  assign tick   = Enable && (div_cnt == DIV_W'(PIX_DIV - 1));
  assign h_wrap = (h_cnt == X_WIDTH'(H_TOTAL - 1));
  assign v_wrap = (v_cnt == Y_WIDTH'(V_TOTAL - 1));

  // Next position and phase, consumed only on a tick edge
  always_comb begin
    h_cnt_nxt   = h_wrap ? '0 : h_cnt + 1'b1;
    v_cnt_nxt   = v_cnt;
    h_state_nxt = h_state;
    v_state_nxt = v_state;
    if (h_wrap) v_cnt_nxt = v_wrap ? '0 : v_cnt + 1'b1;
    case (h_state)
      H_ACTIVE: if (h_cnt_nxt == X_WIDTH'(H_DISPLAY))    h_state_nxt = H_FRONT;
      H_FRONT:  if (h_cnt_nxt == X_WIDTH'(H_SYNC_START)) h_state_nxt = H_SYNC;
      H_SYNC:   if (h_cnt_nxt == X_WIDTH'(H_BACK_START)) h_state_nxt = H_BACK;
      H_BACK:   if (h_wrap)                             h_state_nxt = H_ACTIVE;
      default:                                          h_state_nxt = H_ACTIVE;
    endcase
    if (h_wrap) begin
      case (v_state)
        V_ACTIVE: if (v_cnt_nxt == Y_WIDTH'(V_DISPLAY))    v_state_nxt = V_FRONT;
        V_FRONT:  if (v_cnt_nxt == Y_WIDTH'(V_SYNC_START)) v_state_nxt = V_SYNC;
        V_SYNC:   if (v_cnt_nxt == Y_WIDTH'(V_BACK_START)) v_state_nxt = V_BACK;
        V_BACK:   if (v_wrap)                             v_state_nxt = V_ACTIVE;
        default:                                          v_state_nxt = V_ACTIVE;
      endcase
    end
    act_nxt    = (h_state_nxt == H_ACTIVE) && (v_state_nxt == V_ACTIVE);
    hs_act_nxt = (h_state_nxt == H_SYNC);
    vs_act_nxt = (v_state_nxt == V_SYNC);
  end

  always_ff @(posedge Clock) begin
    pixelTick  <= 1'b0;
    lineStart  <= 1'b0;
    frameStart <= 1'b0;
    if (Reset) begin
      div_cnt <= '0;
      h_cnt   <= X_WIDTH'(H_TOTAL - 1);
      v_cnt   <= Y_WIDTH'(V_TOTAL - 1);
      h_state <= H_BACK;
      v_state <= V_BACK;
      hSync   <= ~H_SYNC_POL;
      vSync   <= ~V_SYNC_POL;
      sync_n  <= 1'b1;
      blank_n <= 1'b0;
      nextX   <= '0;
      nextY   <= '0;
`ifdef VGA_TIMING_FRAME_COUNT_EN
      frameCount <= '0;
`endif
    end else if (tick) begin
      div_cnt    <= '0;
      h_cnt      <= h_cnt_nxt;
      v_cnt      <= v_cnt_nxt;
      h_state    <= h_state_nxt;
      v_state    <= v_state_nxt;
      hSync      <= hs_act_nxt ? H_SYNC_POL : ~H_SYNC_POL;
      vSync      <= vs_act_nxt ? V_SYNC_POL : ~V_SYNC_POL;
      sync_n     <= ~(hs_act_nxt || vs_act_nxt);
      blank_n    <= act_nxt;
      nextX      <= act_nxt ? h_cnt_nxt : '0;
      nextY      <= act_nxt ? v_cnt_nxt : '0;
      pixelTick  <= 1'b1;
      lineStart  <= h_wrap;
      frameStart <= h_wrap && v_wrap;
`ifdef VGA_TIMING_FRAME_COUNT_EN
      if (h_wrap && v_wrap) frameCount <= frameCount + 16'd1;
`endif
    end else if (Enable) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks three raster configurations against a position-based model of the timing rules.
module tb_vga_timing_gen;

  typedef struct {int hd, hf, hs, hb, vd, vf, vs, vb, hp, vp, dv;} cfg_t;
  typedef struct {int x, y, dv; bit hs, vs, sn, bn, pt, ls, fs; int nx, ny, fc;} mdl_t;

  localparam cfg_t CA = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 1, 1};
  localparam cfg_t CB = '{8, 2, 3, 2, 5, 1, 2, 1, 0, 0, 1};
  localparam cfg_t CC = '{6, 1, 2, 1, 4, 1, 1, 1, 1, 0, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, en_a, en_b, en_c;
  logic a_hs, a_vs, a_sn, a_bn, a_pt, a_ls, a_fs;
  logic b_hs, b_vs, b_sn, b_bn, b_pt, b_ls, b_fs;
  logic c_hs, c_vs, c_sn, c_bn, c_pt, c_ls, c_fs;
  logic [10:0] a_nx, b_nx, c_nx;
  logic [9:0]  a_ny, b_ny, c_ny;
  logic [15:0] a_fc, b_fc, c_fc;

  mdl_t ma, mb, mc;
  int tests = 0, fails = 0;

  vga_timing_gen #(.H_DISPLAY(800), .H_FRONT_PORCH(56), .H_SYNC_PULSE(120), .H_BACK_PORCH(64),
    .V_DISPLAY(600), .V_FRONT_PORCH(37), .V_SYNC_PULSE(6), .V_BACK_PORCH(23),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIX_DIV(1), .X_WIDTH(11), .Y_WIDTH(10)) u_a (
    .Clock(clk), .Reset(rst_a), .Enable(en_a), .hSync(a_hs), .vSync(a_vs), .sync_n(a_sn),
    .blank_n(a_bn), .nextX(a_nx), .nextY(a_ny), .pixelTick(a_pt), .lineStart(a_ls), .frameStart(a_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frameCount(a_fc)
`endif
  );

  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
    .V_DISPLAY(5), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIX_DIV(1), .X_WIDTH(11), .Y_WIDTH(10)) u_b (
    .Clock(clk), .Reset(rst_b), .Enable(en_b), .hSync(b_hs), .vSync(b_vs), .sync_n(b_sn),
    .blank_n(b_bn), .nextX(b_nx), .nextY(b_ny), .pixelTick(b_pt), .lineStart(b_ls), .frameStart(b_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frameCount(b_fc)
`endif
  );

  vga_timing_gen #(.H_DISPLAY(6), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_BACK_PORCH(1),
    .V_DISPLAY(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .PIX_DIV(3), .X_WIDTH(11), .Y_WIDTH(10)) u_c (
    .Clock(clk), .Reset(rst_c), .Enable(en_c), .hSync(c_hs), .vSync(c_vs), .sync_n(c_sn),
    .blank_n(c_bn), .nextX(c_nx), .nextY(c_ny), .pixelTick(c_pt), .lineStart(c_ls), .frameStart(c_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frameCount(c_fc)
`endif
  );

  // Position-level reference: outputs follow directly from (x, y) and the region boundaries
  function automatic mdl_t step(mdl_t m, cfg_t c, bit rst, bit en);
    int ht, vt;
    bit hact, vact;
    mdl_t r;
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    r = m;
    r.pt = 0; r.ls = 0; r.fs = 0;
    if (rst) begin
      r.x = ht - 1; r.y = vt - 1; r.dv = 0;
      r.hs = (c.hp == 0); r.vs = (c.vp == 0); r.sn = 1; r.bn = 0;
      r.nx = 0; r.ny = 0; r.fc = 0;
      return r;
    end
    if (!en) return r;
    if (m.dv != c.dv - 1) begin
      r.dv = m.dv + 1;
      return r;
    end
    r.dv = 0; r.pt = 1;
    r.x = (m.x + 1) % ht;
    if (r.x == 0) begin
      r.ls = 1;
      r.y = (m.y + 1) % vt;
      if (r.y == 0) begin
        r.fs = 1;
        r.fc = (m.fc + 1) % 65536;
      end
    end
    hact = (r.x >= c.hd + c.hf) && (r.x < c.hd + c.hf + c.hs);
    vact = (r.y >= c.vd + c.vf) && (r.y < c.vd + c.vf + c.vs);
    r.hs = hact ? (c.hp != 0) : (c.hp == 0);
    r.vs = vact ? (c.vp != 0) : (c.vp == 0);
    r.sn = !(hact || vact);
    r.bn = (r.x < c.hd) && (r.y < c.vd);
    r.nx = r.bn ? r.x : 0;
    r.ny = r.bn ? r.y : 0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_hsync", a_hs, ma.hs); chk("a_vsync", a_vs, ma.vs); chk("a_sync_n", a_sn, ma.sn);
    chk("a_blank_n", a_bn, ma.bn); chk("a_nextx", a_nx, ma.nx); chk("a_nexty", a_ny, ma.ny);
    chk("a_ptick", a_pt, ma.pt); chk("a_lstart", a_ls, ma.ls); chk("a_fstart", a_fs, ma.fs);
    chk("b_hsync", b_hs, mb.hs); chk("b_vsync", b_vs, mb.vs); chk("b_sync_n", b_sn, mb.sn);
    chk("b_blank_n", b_bn, mb.bn); chk("b_nextx", b_nx, mb.nx); chk("b_nexty", b_ny, mb.ny);
    chk("b_ptick", b_pt, mb.pt); chk("b_lstart", b_ls, mb.ls); chk("b_fstart", b_fs, mb.fs);
    chk("c_hsync", c_hs, mc.hs); chk("c_vsync", c_vs, mc.vs); chk("c_sync_n", c_sn, mc.sn);
    chk("c_blank_n", c_bn, mc.bn); chk("c_nextx", c_nx, mc.nx); chk("c_nexty", c_ny, mc.ny);
    chk("c_ptick", c_pt, mc.pt); chk("c_lstart", c_ls, mc.ls); chk("c_fstart", c_fs, mc.fs);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk("a_fcount", a_fc, ma.fc); chk("b_fcount", b_fc, mb.fc); chk("c_fcount", c_fc, mc.fc);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    ma = step(ma, CA, rst_a, en_a);
    mb = step(mb, CB, rst_b, en_b);
    mc = step(mc, CC, rst_c, en_c);
    #1;
    check_all();
  endtask

  initial begin
    int hs_cnt, hs_first, bn_low, c_ticks;
    int a_ls_cyc[$];
    int b_fs_cyc[$];
    hs_cnt = 0; hs_first = 0; bn_low = 0; c_ticks = 0;
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    a_fc = '0; b_fc = '0; c_fc = '0;

    rst_a = 1; rst_b = 1; rst_c = 1; en_a = 1; en_b = 1; en_c = 1;
    cycle();
    cycle();
    chk("rst_a_hsync", a_hs, 0); chk("rst_b_hsync", b_hs, 1); chk("rst_b_vsync", b_vs, 1);
    chk("rst_a_sync_n", a_sn, 1); chk("rst_a_blank_n", a_bn, 0); chk("rst_a_fstart", a_fs, 0);

    rst_a = 0; rst_b = 0; rst_c = 0;
    for (int k = 1; k <= 1300; k++) begin
      en_c  = (k <= 300) ? (((k - 1) / 5) % 2 == 0) : 1'($urandom_range(0, 1));
      rst_b = (k == 600);
      cycle();
      if (k <= 1040 && a_hs === 1'b1) begin
        hs_cnt++;
        if (hs_first == 0) hs_first = k;
      end
      if (k <= 1040 && a_bn === 1'b0) bn_low++;
      if (k <= 300 && c_pt === 1'b1) c_ticks++;
      if (a_ls === 1'b1) a_ls_cyc.push_back(k);
      if (b_fs === 1'b1) b_fs_cyc.push_back(k);
      if (k == 1) begin
        chk("first_fstart", a_fs, 1); chk("first_lstart", a_ls, 1); chk("first_ptick", a_pt, 1);
        chk("first_blank_n", a_bn, 1); chk("first_nextx", a_nx, 0); chk("first_nexty", a_ny, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk("first_fcount", a_fc, 1);
`endif
      end
      if (k == 2) begin
        chk("second_fstart", a_fs, 0); chk("second_nextx", a_nx, 1);
      end
`ifdef VGA_TIMING_FRAME_COUNT_EN
      if (k == 271) chk("b_fcount_three", b_fc, 3);
`endif
      if (k == 600) begin
        chk("midrst_fstart", b_fs, 0); chk("midrst_hsync", b_hs, 1); chk("midrst_blank_n", b_bn, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk("midrst_fcount", b_fc, 0);
`endif
      end
      if (k == 601) begin
        chk("postrst_fstart", b_fs, 1); chk("postrst_nextx", b_nx, 0); chk("postrst_nexty", b_ny, 0);
      end
    end

    chk("a_hsync_width", hs_cnt, 120);
    chk("a_hsync_start", hs_first - 1, 856);
    chk("a_blank_low", bn_low, 240);
    chk("a_line_period", (a_ls_cyc.size() >= 2) ? a_ls_cyc[1] - a_ls_cyc[0] : 0, 1040);
    chk("b_frame_period1", (b_fs_cyc.size() >= 3) ? b_fs_cyc[1] - b_fs_cyc[0] : 0, 135);
    chk("b_frame_period2", (b_fs_cyc.size() >= 3) ? b_fs_cyc[2] - b_fs_cyc[1] : 0, 135);
    chk("c_tick_count", c_ticks, 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
